// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   DefWidth : default operand width in bits
//   DefCntW  : default iteration counter width (2**DefCntW > DefWidth)
//   PW       : product width for the default operand width
//   state_e  : multiplier controller states
package mul_pkg;

  localparam int unsigned DefWidth = 6;
  localparam int unsigned DefCntW  = 3;
  localparam int unsigned PW       = 2 * DefWidth;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full_adder cells.
// Purely combinational.
//   a, b : addends
//   cin  : carry in
//   sum  : WIDTH-bit sum
//   cout : carry out of the MSB
module rca_adder #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mul_6x6.sv
// Iterative shift-and-add unsigned multiplier, one operand pair per transaction.
// Operands are taken over a valid/ready handshake in IDLE, WIDTH add/shift
// iterations run in CALC, and the product is presented in DONE until accepted.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b                 : multiplicand / multiplier, unsigned
//   out_valid, out_ready : product handshake
//   product              : a*b, 2*WIDTH bits
//   busy                 : high in CALC or DONE
// Optional build macro SEQ_MUL_ZERO_SKIP_EN: a zero operand short-cuts the
// iteration so the product is presented after a single cycle.
module seq_mul_6x6
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // The adder always runs; only its second operand is gated by the multiplier bit.
  assign addend = acc_lo_q[0] ? mcand_q : '0;

  rca_adder #(
    .WIDTH (WIDTH)
  ) u_rca_adder (
    .a    (acc_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = StCalc;
`ifdef SEQ_MUL_ZERO_SKIP_EN
          // Zero accumulator plus a pre-expired counter: the single remaining
          // iteration adds nothing, so DONE follows one edge later with product 0.
          if (a == '0 || b == '0) begin
            acc_lo_d = '0;
            cnt_d    = CNT_W'(WIDTH - 1);
          end
`endif
        end
      end
      StCalc: begin
        // Right shift of {cout, sum, acc_lo}; the dropped LSB was the consumed multiplier bit.
        acc_hi_d = {cout, sum[WIDTH-1:1]};
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StCalc) || (state_q == StDone);
    product   = {acc_hi_q, acc_lo_q};
  end

endmodule

// File: tb/tb_seq_mul_6x6.sv
module tb_seq_mul_6x6;
  import mul_pkg::*;

  localparam int unsigned W = DefWidth;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  seq_mul_6x6 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  va;
    logic [W-1:0]  vb;
    logic [PW-1:0] vp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MUL_ZERO_SKIP_EN
    if (x == '0 || y == '0) return 1;
`endif
    return W;
  endfunction

  // Step to the next falling edge (one full clock).
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction: offer operands, measure edges from acceptance to out_valid,
  // hold out_ready low for 'hold' cycles while poking in_valid, then accept.
  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [PW-1:0] expp,
                     input int unsigned hold, input string name);
    int lat;
    a         = ta;
    b         = tb_;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    // Operands are sampled only at acceptance; scramble them afterwards.
    a = ~ta;
    b = ~tb_;
    check({name, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat(ta, tb_)));
    check({name, " product"}, 32'(product), 32'(expp));
    for (int i = 0; i < int'(hold); i++) begin
      in_valid = 1'b1;
      a = W'(i + 1);
      b = W'(i + 2);
      step();
      check({name, " held product"}, 32'(product), 32'(expp));
      check({name, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " out_valid cleared"}, 32'(out_valid), 32'd0);
    check({name, " back idle"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{va: 6'd5,  vb: 6'd3,  vp: 12'd15};
    vecs[1] = '{va: 6'd63, vb: 6'd63, vp: 12'd3969};
    vecs[2] = '{va: 6'd0,  vb: 6'd42, vp: 12'd0};
    vecs[3] = '{va: 6'd42, vb: 6'd0,  vp: 12'd0};
    vecs[4] = '{va: 6'd1,  vb: 6'd1,  vp: 12'd1};
    vecs[5] = '{va: 6'd63, vb: 6'd1,  vp: 12'd63};
    vecs[6] = '{va: 6'd1,  vb: 6'd63, vp: 12'd63};
    vecs[7] = '{va: 6'd32, vb: 6'd32, vp: 12'd1024};
    vecs[8] = '{va: 6'd21, vb: 6'd42, vp: 12'd882};
    vecs[9] = '{va: 6'd13, vb: 6'd57, vp: 12'd741};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset product", 32'(product), 32'd0);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].va, vecs[i].vb, vecs[i].vp, 0, $sformatf("vec%0d", i));
    end

    // Backpressure: product held, new operands ignored, nothing started afterwards.
    txn(6'd12, 6'd11, 12'd132, 5, "backpressure");
    step();
    check("bp no extra txn busy", 32'(busy), 32'd0);
    check("bp no extra txn out_valid", 32'(out_valid), 32'd0);

    // Reset during CALC discards the transaction.
    a        = 6'd7;
    b        = 6'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midcalc rst in_ready", 32'(in_ready), 32'd1);
    check("midcalc rst out_valid", 32'(out_valid), 32'd0);
    check("midcalc rst busy", 32'(busy), 32'd0);
    check("midcalc rst product", 32'(product), 32'd0);
    txn(6'd7, 6'd9, 12'd63, 0, "after rst");

    // Reset wins over a simultaneous out_ready in DONE.
    a        = 6'd3;
    b        = 6'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (W) step();
    check("done before rst", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    check("done rst product", 32'(product), 32'd0);
    check("done rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom_range(0, 63));
      rb = W'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) step();
      txn(ra, rb, PW'(ra) * PW'(rb), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
